// File: rtl/sgmii_multi_regs_if.sv
// -----------------------------------------------------------------------------
// sgmii_multi_regs_if
// Pipelined Wishbone bus bundle between a host master and the multi-lane
// SGMII register block.
//   i_Cyc, i_Stb, i_WEn : cycle, strobe, write enable (master -> slave)
//   i12_Addr            : byte address, [11:7] channel, [6:2] register
//   i32_WrData          : write data, only [15:0] is meaningful
//   o32_RdData          : registered read data (slave -> master)
//   o_Ack               : one-cycle acknowledge
//   o_Stall             : request not accepted this cycle
// -----------------------------------------------------------------------------
interface sgmii_multi_regs_if;
    logic        i_Cyc;
    logic        i_Stb;
    logic        i_WEn;
    logic [11:0] i12_Addr;
    logic [31:0] i32_WrData;
    logic [31:0] o32_RdData;
    logic        o_Ack;
    logic        o_Stall;

    modport master (
        output i_Cyc, i_Stb, i_WEn, i12_Addr, i32_WrData,
        input  o32_RdData, o_Ack, o_Stall
    );

    modport slave (
        input  i_Cyc, i_Stb, i_WEn, i12_Addr, i32_WrData,
        output o32_RdData, o_Ack, o_Stall
    );
endinterface

// File: rtl/sgmii_multi_regs.sv
// -----------------------------------------------------------------------------
// sgmii_multi_regs
// NUM_CH independent clause-22-style SGMII/1000BASE-X management register sets
// behind one pipelined Wishbone slave, with latch-low link status, per-lane
// W1C interrupt status/mask and a registered aggregated interrupt.
//
// Ports:
//   i_Clk, w_ARstLogic_L : clock, asynchronous active-low reset
//   wb                   : Wishbone slave bundle (see sgmii_multi_regs_if)
//   o_Irq                : registered OR of all unmasked interrupt bits
//   iN3_XmitState        : per-lane transmit state (3'b001 = CONFIG)
//   iN16_TxConfigReg     : per-lane transmitted config word
//   iN16_LpAdvAbility    : per-lane link-partner ability
//   iN_ANComplete        : per-lane auto-negotiation complete
//   iN_SyncStatus        : per-lane code-group sync
//   oN2_SGMIISpeed, oN_SGMIIDuplex : per-lane resolved speed / duplex
//   oN_MIIRst_L, oN_ANEnable, oN_ANRestart, oN_Loopback, oN_GXBPowerDown :
//                          per-lane control bits from the Ctrl register
//   oN21_LinkTimer       : per-lane link timer
//   oN16_LcAdvAbility    : per-lane local advertised ability
//
// Address map: channel 31 holds globals (0x00 revision, 0x01 IRQ summary);
// channels 0..NUM_CH-1 hold lane registers; everything else reads 0 and
// ignores writes.
// -----------------------------------------------------------------------------
module sgmii_multi_regs #(
    parameter int          NUM_CH             = 4,
    parameter logic [20:0] LINK_TIMER_DEFAULT = 21'h1312D0,
    parameter logic [15:0] REV                = 16'h2000
) (
    input  logic                 i_Clk,
    input  logic                 w_ARstLogic_L,
    sgmii_multi_regs_if.slave    wb,
    output logic                 o_Irq,
    input  logic [NUM_CH*3-1:0]  iN3_XmitState,
    input  logic [NUM_CH*16-1:0] iN16_TxConfigReg,
    input  logic [NUM_CH*16-1:0] iN16_LpAdvAbility,
    input  logic [NUM_CH-1:0]    iN_ANComplete,
    input  logic [NUM_CH-1:0]    iN_SyncStatus,
    output logic [NUM_CH*2-1:0]  oN2_SGMIISpeed,
    output logic [NUM_CH-1:0]    oN_SGMIIDuplex,
    output logic [NUM_CH-1:0]    oN_MIIRst_L,
    output logic [NUM_CH-1:0]    oN_ANEnable,
    output logic [NUM_CH-1:0]    oN_ANRestart,
    output logic [NUM_CH-1:0]    oN_Loopback,
    output logic [NUM_CH-1:0]    oN_GXBPowerDown,
    output logic [NUM_CH*21-1:0] oN21_LinkTimer,
    output logic [NUM_CH*16-1:0] oN16_LcAdvAbility
);

    localparam logic [2:0] XMIT_CONFIG = 3'b001;

    localparam logic [4:0] REG_CTRL    = 5'h00;
    localparam logic [4:0] REG_STATUS  = 5'h01;
    localparam logic [4:0] REG_ADV     = 5'h04;
    localparam logic [4:0] REG_LP      = 5'h05;
    localparam logic [4:0] REG_TMR_LO  = 5'h08;
    localparam logic [4:0] REG_TMR_HI  = 5'h09;
    localparam logic [4:0] REG_SCRATCH = 5'h0A;
    localparam logic [4:0] REG_INTSTAT = 5'h10;
    localparam logic [4:0] REG_INTMASK = 5'h11;
    localparam logic [4:0] REG_MODE    = 5'h1F;

    logic                 ack_r;
    logic [31:0]          rd_data_r;
    logic                 irq_r;
    logic                 accept_s;
    logic                 wr_s;
    logic                 rd_s;
    logic [4:0]           ch_s;
    logic [4:0]           reg_s;
    logic [15:0]          wdata_s;
    logic [NUM_CH*16-1:0] lane_rd_s;
    logic [NUM_CH-1:0]    pend_s;
    logic [31:0]          rd_mux_s;
    logic                 unused_wdata_s;

    // Stall is simply the ack cycle: one access every two cycles.
    assign accept_s       = wb.i_Cyc & wb.i_Stb & ~ack_r;
    assign wr_s           = accept_s & wb.i_WEn;
    assign rd_s           = accept_s & ~wb.i_WEn;
    assign ch_s           = wb.i12_Addr[11:7];
    assign reg_s          = wb.i12_Addr[6:2];
    assign wdata_s        = wb.i32_WrData[15:0];
    assign unused_wdata_s = ^wb.i32_WrData[31:16];

    assign wb.o_Ack      = ack_r;
    assign wb.o_Stall    = ack_r;
    assign wb.o32_RdData = rd_data_r;
    assign o_Irq         = irq_r;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic        hit_s;
        logic [2:0]  xmit_s;
        logic [15:0] txcfg_s;
        logic [15:0] lp_s;
        logic        an_s;
        logic        sync_s;

        logic [15:0] ctrl_r;
        logic [15:0] adv_r;
        logic [15:0] scratch_r;
        logic [15:0] lp_prev_r;
        logic [20:0] timer_r;
        logic [2:0]  stat_r;
        logic [2:0]  mask_r;
        logic [2:0]  mode_r;
        logic        latch_r;
        logic        sync_prev_r;
        logic        an_prev_r;

        logic [15:0] ctrl_nxt_s;
        logic        latch_nxt_s;
        logic [2:0]  set_s;
        logic [2:0]  w1c_s;
        logic [2:0]  stat_nxt_s;
        logic [15:0] rd_s_lane;
        logic [15:0] lcadv_s;
        logic [1:0]  speed_s;
        logic        duplex_s;

        assign hit_s   = (ch_s == 5'(c));
        assign xmit_s  = iN3_XmitState[c*3 +: 3];
        assign txcfg_s = iN16_TxConfigReg[c*16 +: 16];
        assign lp_s    = iN16_LpAdvAbility[c*16 +: 16];
        assign an_s    = iN_ANComplete[c];
        assign sync_s  = iN_SyncStatus[c];

        // Next-state for Ctrl, link latch and interrupt status.
        always_comb begin
            ctrl_nxt_s     = ctrl_r;
            // Reset bit only ever lives for one cycle after a write.
            ctrl_nxt_s[15] = 1'b0;
            ctrl_nxt_s[9]  = ctrl_r[9] & (xmit_s != XMIT_CONFIG);
            if (wr_s && hit_s && (reg_s == REG_CTRL)) begin
                ctrl_nxt_s = wdata_s;
            end else begin
                ctrl_nxt_s = ctrl_nxt_s;
            end

            // Loss of sync dominates a concurrent status read.
            if (!sync_s) begin
                latch_nxt_s = 1'b0;
            end else if (rd_s && hit_s && (reg_s == REG_STATUS)) begin
                latch_nxt_s = 1'b1;
            end else begin
                latch_nxt_s = latch_r;
            end

            set_s = {(lp_s != lp_prev_r), (an_s & ~an_prev_r), (~sync_s & sync_prev_r)};
            if (wr_s && hit_s && (reg_s == REG_INTSTAT)) begin
                w1c_s = wdata_s[2:0];
            end else begin
                w1c_s = 3'b000;
            end
            // New events override a clear landing on the same edge.
            stat_nxt_s = (stat_r & ~w1c_s) | set_s;
        end

        // Lane register state.
        always_ff @(posedge i_Clk or negedge w_ARstLogic_L) begin
            if (!w_ARstLogic_L) begin
                ctrl_r      <= 16'h1140;
                adv_r       <= 16'h01A0;
                scratch_r   <= 16'h0000;
                lp_prev_r   <= 16'h0000;
                timer_r     <= LINK_TIMER_DEFAULT;
                stat_r      <= 3'b000;
                mask_r      <= 3'b000;
                mode_r      <= 3'b000;
                latch_r     <= 1'b0;
                sync_prev_r <= 1'b0;
                an_prev_r   <= 1'b0;
            end else begin
                ctrl_r      <= ctrl_nxt_s;
                latch_r     <= latch_nxt_s;
                stat_r      <= stat_nxt_s;
                lp_prev_r   <= lp_s;
                sync_prev_r <= sync_s;
                an_prev_r   <= an_s;
                if (wr_s && hit_s) begin
                    case (reg_s)
                        REG_ADV:     adv_r          <= wdata_s;
                        REG_TMR_LO:  timer_r[15:0]  <= wdata_s;
                        REG_TMR_HI:  timer_r[20:16] <= wdata_s[4:0];
                        REG_SCRATCH: scratch_r      <= wdata_s;
                        REG_INTMASK: mask_r         <= wdata_s[2:0];
                        REG_MODE:    mode_r         <= wdata_s[2:0];
                        default:     scratch_r      <= scratch_r;
                    endcase
                end else begin
                    adv_r <= adv_r;
                end
            end
        end

        // Lane read mux, advertised ability and speed/duplex resolution.
        always_comb begin
            case (reg_s)
                REG_CTRL:    rd_s_lane = ctrl_r;
                REG_STATUS:  rd_s_lane = {10'h000, an_s, 2'b01, latch_r, 2'b00};
                REG_ADV:     rd_s_lane = adv_r;
                REG_LP:      rd_s_lane = lp_s;
                REG_TMR_LO:  rd_s_lane = timer_r[15:0];
                REG_TMR_HI:  rd_s_lane = {11'h000, timer_r[20:16]};
                REG_SCRATCH: rd_s_lane = scratch_r;
                REG_INTSTAT: rd_s_lane = {13'h0000, stat_r};
                REG_INTMASK: rd_s_lane = {13'h0000, mask_r};
                REG_MODE:    rd_s_lane = {13'h0000, mode_r};
                default:     rd_s_lane = 16'h0000;
            endcase

            if (mode_r[0]) begin
                lcadv_s = {1'b0, txcfg_s[15], 1'b0, 3'b000, 10'h001};
            end else begin
                lcadv_s = {1'b0, txcfg_s[15], adv_r[13:12], 3'b000, adv_r[8:7], 2'b01, 5'b00000};
            end

            if (!mode_r[0]) begin
                speed_s  = 2'b10;
                duplex_s = 1'b1;
            end else if (!mode_r[2]) begin
                speed_s  = lp_s[11:10];
                duplex_s = lp_s[12];
            end else begin
                speed_s  = {ctrl_r[6], ctrl_r[13]};
                duplex_s = ctrl_r[8];
            end
        end

        assign lane_rd_s[c*16 +: 16]      = hit_s ? rd_s_lane : 16'h0000;
        assign pend_s[c]                  = |(stat_r & mask_r);
        assign oN_ANRestart[c]            = ctrl_r[9];
        assign oN_MIIRst_L[c]             = ~ctrl_r[15];
        assign oN_ANEnable[c]             = ctrl_r[12];
        assign oN_Loopback[c]             = ctrl_r[14];
        assign oN_GXBPowerDown[c]         = ctrl_r[11];
        assign oN21_LinkTimer[c*21 +: 21] = timer_r;
        assign oN16_LcAdvAbility[c*16 +: 16] = lcadv_s;
        assign oN2_SGMIISpeed[c*2 +: 2]   = speed_s;
        assign oN_SGMIIDuplex[c]          = duplex_s;
    end

    // Top-level read mux: globals on channel 31, lanes OR-combined by hit.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        if (ch_s == 5'd31) begin
            case (reg_s)
                5'h00:   rd_mux_s = {16'h0000, REV};
                5'h01:   rd_mux_s = 32'(pend_s);
                default: rd_mux_s = 32'h0000_0000;
            endcase
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_mux_s = rd_mux_s | {16'h0000, lane_rd_s[c*16 +: 16]};
            end
        end
    end

    // Bus acknowledge, read data capture and interrupt aggregation.
    always_ff @(posedge i_Clk or negedge w_ARstLogic_L) begin
        if (!w_ARstLogic_L) begin
            ack_r     <= 1'b0;
            rd_data_r <= 32'h0000_0000;
            irq_r     <= 1'b0;
        end else begin
            ack_r <= accept_s;
            irq_r <= |pend_s;
            if (accept_s) begin
                rd_data_r <= rd_s ? rd_mux_s : 32'h0000_0000;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

endmodule

// File: tb/tb_sgmii_multi_regs.sv
// -----------------------------------------------------------------------------
// tb_sgmii_multi_regs
// Directed self-checking bench for sgmii_multi_regs with NUM_CH = 4.
// -----------------------------------------------------------------------------
module tb_sgmii_multi_regs;
    localparam int         NUM_CH  = 4;
    localparam logic [2:0] X_IDLE  = 3'b010;
    localparam logic [2:0] X_CONF  = 3'b001;

    logic clk;
    logic rst_n;
    logic irq;
    logic [NUM_CH*3-1:0]  xmit;
    logic [NUM_CH*16-1:0] txcfg;
    logic [NUM_CH*16-1:0] lp;
    logic [NUM_CH-1:0]    an;
    logic [NUM_CH-1:0]    sync;
    logic [NUM_CH*2-1:0]  speed;
    logic [NUM_CH-1:0]    duplex, mii_rst_l, an_en, an_restart, loopback, gxb_pd;
    logic [NUM_CH*21-1:0] link_timer;
    logic [NUM_CH*16-1:0] lc_adv;

    int n_checks = 0;
    int n_fails  = 0;

    sgmii_multi_regs_if wb_if ();

    sgmii_multi_regs #(.NUM_CH(NUM_CH)) dut (
        .i_Clk            (clk),
        .w_ARstLogic_L    (rst_n),
        .wb               (wb_if),
        .o_Irq            (irq),
        .iN3_XmitState    (xmit),
        .iN16_TxConfigReg (txcfg),
        .iN16_LpAdvAbility(lp),
        .iN_ANComplete    (an),
        .iN_SyncStatus    (sync),
        .oN2_SGMIISpeed   (speed),
        .oN_SGMIIDuplex   (duplex),
        .oN_MIIRst_L      (mii_rst_l),
        .oN_ANEnable      (an_en),
        .oN_ANRestart     (an_restart),
        .oN_Loopback      (loopback),
        .oN_GXBPowerDown  (gxb_pd),
        .oN21_LinkTimer   (link_timer),
        .oN16_LcAdvAbility(lc_adv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] adr(input int ch, input int rg);
        return {5'(ch), 5'(rg), 2'b00};
    endfunction

    // One bus access; returns at the falling edge of the ack cycle.
    task automatic xfer(input logic we, input logic [11:0] a, input logic [15:0] wd,
                        output logic [31:0] rd, output int lat, output logic stall_at_ack);
        logic got;
        @(negedge clk);
        wb_if.i_Cyc = 1'b1; wb_if.i_Stb = 1'b1; wb_if.i_WEn = we;
        wb_if.i12_Addr = a; wb_if.i32_WrData = {16'h0000, wd};
        @(posedge clk); #1;
        wb_if.i_Cyc = 1'b0; wb_if.i_Stb = 1'b0; wb_if.i_WEn = 1'b0;
        got = 1'b0; lat = 0; stall_at_ack = 1'b0; rd = 32'h0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (wb_if.o_Ack === 1'b1) begin
                got = 1'b1; rd = wb_if.o32_RdData; stall_at_ack = wb_if.o_Stall;
            end else begin
                lat++; @(posedge clk); #1;
            end
        end
        if (!got) begin
            n_checks++; n_fails++;
            $display("FAIL ack_timeout addr=%h got no ack want ack", a);
        end
        @(negedge clk);
    endtask

    task automatic rd_reg(input int ch, input int rg, output logic [31:0] d);
        int l; logic s;
        xfer(1'b0, adr(ch, rg), 16'h0000, d, l, s);
    endtask

    task automatic wr_reg(input int ch, input int rg, input logic [15:0] v);
        logic [31:0] d; int l; logic s;
        xfer(1'b1, adr(ch, rg), v, d, l, s);
    endtask

    task automatic test_reset();
        logic [31:0] d; int l; logic s;
        n_checks++; if (wb_if.o_Ack !== 1'b0) begin n_fails++; $display("FAIL rst_ack got %b want 0", wb_if.o_Ack); end
        n_checks++; if (wb_if.o32_RdData !== 32'h0) begin n_fails++; $display("FAIL rst_rddata got %h want 0", wb_if.o32_RdData); end
        n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL rst_irq got %b want 0", irq); end
        n_checks++; if ({mii_rst_l, an_en, an_restart, loopback, gxb_pd} !== {4'hF, 4'hF, 4'h0, 4'h0, 4'h0})
            begin n_fails++; $display("FAIL rst_ctrl_outs got %h", {mii_rst_l, an_en, an_restart, loopback, gxb_pd}); end
        n_checks++; if (link_timer[20:0] !== 21'h1312D0 || link_timer[83:63] !== 21'h1312D0)
            begin n_fails++; $display("FAIL rst_timer got %h want 1312d0", link_timer[20:0]); end
        n_checks++; if (lc_adv[15:0] !== 16'h01A0) begin n_fails++; $display("FAIL rst_lcadv got %h want 01a0", lc_adv[15:0]); end
        n_checks++; if (speed !== 8'hAA || duplex !== 4'hF) begin n_fails++; $display("FAIL rst_speed got %h/%h want aa/f", speed, duplex); end
        xfer(1'b0, adr(0, 0), 16'h0000, d, l, s);
        n_checks++; if (d !== 32'h0000_1140) begin n_fails++; $display("FAIL rd_ch0_ctrl got %h want 00001140", d); end
        n_checks++; if (l !== 0) begin n_fails++; $display("FAIL ack_latency got %0d want 0", l); end
        n_checks++; if (s !== 1'b1) begin n_fails++; $display("FAIL stall_in_ack got %b want 1", s); end
        @(posedge clk); #1;
        n_checks++; if (wb_if.o_Ack !== 1'b0) begin n_fails++; $display("FAIL ack_one_cycle got %b want 0", wb_if.o_Ack); end
        n_checks++; if (wb_if.o32_RdData !== 32'h0000_1140) begin n_fails++; $display("FAIL rddata_hold got %h want 1140", wb_if.o32_RdData); end
    endtask

    task automatic test_ctrl();
        logic [31:0] d;
        wr_reg(2, 0, 16'h8200);
        n_checks++; if (mii_rst_l[2] !== 1'b0) begin n_fails++; $display("FAIL mii_rst_pulse got %b want 0", mii_rst_l[2]); end
        n_checks++; if (an_restart[2] !== 1'b1) begin n_fails++; $display("FAIL an_restart_set got %b want 1", an_restart[2]); end
        @(posedge clk); #1;
        n_checks++; if (mii_rst_l[2] !== 1'b1) begin n_fails++; $display("FAIL mii_rst_selfclr got %b want 1", mii_rst_l[2]); end
        rd_reg(2, 0, d);
        n_checks++; if (d !== 32'h0000_0200) begin n_fails++; $display("FAIL ctrl_readback got %h want 00000200", d); end
        xmit[8:6] = X_CONF;
        @(posedge clk); #1;
        n_checks++; if (an_restart[2] !== 1'b0) begin n_fails++; $display("FAIL an_restart_clr got %b want 0", an_restart[2]); end
        // Write while CONFIG: the write holds for its own edge, then clears.
        wr_reg(2, 0, 16'h0200);
        n_checks++; if (an_restart[2] !== 1'b1) begin n_fails++; $display("FAIL an_restart_wr_wins got %b want 1", an_restart[2]); end
        @(posedge clk); #1;
        n_checks++; if (an_restart[2] !== 1'b0) begin n_fails++; $display("FAIL an_restart_reclr got %b want 0", an_restart[2]); end
        xmit[8:6] = X_IDLE;
    endtask

    task automatic test_link_latch();
        logic [31:0] d;
        rd_reg(1, 1, d);
        n_checks++; if (d !== 32'h0000_0008) begin n_fails++; $display("FAIL status_first got %h want 00000008", d); end
        rd_reg(1, 1, d);
        n_checks++; if (d !== 32'h0000_000C) begin n_fails++; $display("FAIL status_latched got %h want 0000000c", d); end
        @(negedge clk); sync[1] = 1'b0;
        @(negedge clk); sync[1] = 1'b1;
        rd_reg(1, 1, d);
        n_checks++; if (d !== 32'h0000_0008) begin n_fails++; $display("FAIL status_after_drop got %h want 00000008", d); end
        rd_reg(1, 1, d);
        n_checks++; if (d !== 32'h0000_000C) begin n_fails++; $display("FAIL status_reload got %h want 0000000c", d); end
        rd_reg(1, 16, d);
        n_checks++; if (d !== 32'h0000_0001) begin n_fails++; $display("FAIL intstat_syncloss got %h want 00000001", d); end
        n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL irq_masked got %b want 0", irq); end
        wr_reg(1, 16, 16'h0001);
        rd_reg(1, 16, d);
        n_checks++; if (d !== 32'h0) begin n_fails++; $display("FAIL intstat_w1c got %h want 0", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        wr_reg(3, 17, 16'h0002);
        @(negedge clk); an[3] = 1'b1;
        @(negedge clk); an[3] = 1'b0;
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fails++; $display("FAIL irq_raise got %b want 1", irq); end
        rd_reg(31, 1, d);
        n_checks++; if (d !== 32'h0000_0008) begin n_fails++; $display("FAIL irq_summary got %h want 00000008", d); end
        rd_reg(3, 16, d);
        n_checks++; if (d !== 32'h0000_0002) begin n_fails++; $display("FAIL intstat_an got %h want 00000002", d); end
        wr_reg(3, 16, 16'h0002);
        n_checks++; if (irq !== 1'b1) begin n_fails++; $display("FAIL irq_lag got %b want 1", irq); end
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL irq_clear got %b want 0", irq); end
        // W1C and a fresh event on the same edge.
        @(negedge clk);
        an[3] = 1'b1;
        wb_if.i_Cyc = 1'b1; wb_if.i_Stb = 1'b1; wb_if.i_WEn = 1'b1;
        wb_if.i12_Addr = adr(3, 16); wb_if.i32_WrData = 32'h0000_0002;
        @(posedge clk); #1;
        wb_if.i_Cyc = 1'b0; wb_if.i_Stb = 1'b0; wb_if.i_WEn = 1'b0;
        n_checks++; if (wb_if.o_Ack !== 1'b1) begin n_fails++; $display("FAIL ack_same_edge got %b want 1", wb_if.o_Ack); end
        @(negedge clk); an[3] = 1'b0;
        rd_reg(3, 16, d);
        n_checks++; if (d !== 32'h0000_0002) begin n_fails++; $display("FAIL set_beats_w1c got %h want 00000002", d); end
        wr_reg(3, 16, 16'h0007);
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL irq_final_clear got %b want 0", irq); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        rd_reg(NUM_CH, 0, d);
        n_checks++; if (d !== 32'h0) begin n_fails++; $display("FAIL unmapped_ch_rd got %h want 0", d); end
        wr_reg(NUM_CH, 0, 16'h8000);
        n_checks++; if (mii_rst_l !== 4'hF) begin n_fails++; $display("FAIL unmapped_ch_wr got %h want f", mii_rst_l); end
        rd_reg(0, 0, d);
        n_checks++; if (d !== 32'h0000_1140) begin n_fails++; $display("FAIL ch0_untouched got %h want 00001140", d); end
        rd_reg(0, 2, d);
        n_checks++; if (d !== 32'h0) begin n_fails++; $display("FAIL unmapped_reg got %h want 0", d); end
        rd_reg(31, 0, d);
        n_checks++; if (d !== 32'h0000_2000) begin n_fails++; $display("FAIL rev got %h want 00002000", d); end
        wr_reg(0, 10, 16'hBEEF);
        rd_reg(0, 10, d);
        n_checks++; if (d !== 32'h0000_BEEF) begin n_fails++; $display("FAIL scratch got %h want 0000beef", d); end
        wr_reg(0, 8, 16'h1234);
        wr_reg(0, 9, 16'h001F);
        n_checks++; if (link_timer[20:0] !== 21'h1F1234) begin n_fails++; $display("FAIL timer_wr got %h want 1f1234", link_timer[20:0]); end
        rd_reg(0, 9, d);
        n_checks++; if (d !== 32'h0000_001F) begin n_fails++; $display("FAIL timer_hi_rd got %h want 0000001f", d); end
        txcfg[15:0] = 16'h8000;
        wr_reg(0, 4, 16'h3180);
        n_checks++; if (lc_adv[15:0] !== 16'h71A0) begin n_fails++; $display("FAIL lcadv_1000x got %h want 71a0", lc_adv[15:0]); end
    endtask

    task automatic test_mode();
        logic [31:0] d;
        wr_reg(1, 31, 16'h0005);
        wr_reg(1, 0, 16'h1140);
        n_checks++; if (speed[3:2] !== 2'b10) begin n_fails++; $display("FAIL speed_local got %b want 10", speed[3:2]); end
        n_checks++; if (duplex[1] !== 1'b1) begin n_fails++; $display("FAIL duplex_local got %b want 1", duplex[1]); end
        n_checks++; if (lc_adv[31:16] !== 16'h0001) begin n_fails++; $display("FAIL lcadv_sgmii got %h want 0001", lc_adv[31:16]); end
        wr_reg(1, 0, 16'h2000);
        n_checks++; if (speed[3:2] !== 2'b01 || duplex[1] !== 1'b0) begin n_fails++; $display("FAIL speed_local2 got %b/%b want 01/0", speed[3:2], duplex[1]); end
        lp[31:16] = 16'h1400;
        wr_reg(1, 31, 16'h0001);
        n_checks++; if (speed[3:2] !== 2'b01 || duplex[1] !== 1'b1) begin n_fails++; $display("FAIL speed_lp got %b/%b want 01/1", speed[3:2], duplex[1]); end
        rd_reg(1, 5, d);
        n_checks++; if (d !== 32'h0000_1400) begin n_fails++; $display("FAIL lp_read got %h want 00001400", d); end
        rd_reg(1, 16, d);
        n_checks++; if (d !== 32'h0000_0004) begin n_fails++; $display("FAIL intstat_lp got %h want 00000004", d); end
    endtask

    initial begin
        rst_n = 1'b0;
        wb_if.i_Cyc = 1'b0; wb_if.i_Stb = 1'b0; wb_if.i_WEn = 1'b0;
        wb_if.i12_Addr = 12'h000; wb_if.i32_WrData = 32'h0;
        xmit  = {NUM_CH{X_IDLE}};
        txcfg = '0;
        lp    = '0;
        an    = '0;
        sync  = '1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_ctrl();
        test_link_latch();
        test_irq();
        test_unmapped();
        test_mode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
